// File: rtl/ritc_fifo_sync_ctrl.sv
// Start-up and lock supervisor for a bank of phase-absorbing FIFOs: pulses the read-side reset,
// waits for every begin-read flag, demands a stable window before LOCKED, retries and re-locks.
module ritc_fifo_sync_ctrl #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned RST_LEN     = 4,
   parameter int unsigned TIMEOUT     = 32,
   parameter int unsigned SETTLE      = 8,
   parameter int unsigned MAX_RETRY   = 3,
   parameter bit          AUTO_RELOCK = 1'b1,
   localparam int unsigned RetW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [NCH-1:0]  active_i,
   output logic            fifo_rst_o,
   output logic            busy_o,
   output logic            locked_o,
   output logic            failed_o,
   output logic [RetW-1:0] retries_o,
   output logic [7:0]      loss_count_o
);

   localparam int unsigned CntMax0 = (RST_LEN > TIMEOUT) ? RST_LEN : TIMEOUT;
   localparam int unsigned CntMax  = (CntMax0 > SETTLE) ? CntMax0 : SETTLE;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   typedef enum logic [2:0] {
      StIdle,
      StReset,
      StWait,
      StSettle,
      StLocked,
      StFailed
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [RetW-1:0] retries_q, retries_d;
   logic [7:0]      loss_q, loss_d;
   logic            fifo_rst_q, fifo_rst_d;
   logic            busy_q, busy_d;
   logic            locked_q, locked_d;
   logic            failed_q, failed_d;
   logic            all_active;
   logic            retry;

   assign all_active = &active_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retries_d = retries_q;
      loss_d    = loss_q;
      retry     = 1'b0;

      unique case (state_q)
         StIdle, StFailed: begin
            if (start_i) begin
               state_d   = StReset;
               cnt_d     = '0;
               retries_d = '0;
            end
         end
         StReset: begin
            if (cnt_q == CntW'(RST_LEN - 1)) begin
               state_d = StWait;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWait: begin
            if (all_active) begin
               state_d = StSettle;
               cnt_d   = '0;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               retry = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSettle: begin
            if (!all_active) begin
               retry = 1'b1;
            end else if (cnt_q == CntW'(SETTLE - 1)) begin
               state_d = StLocked;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StLocked: begin
            // A START in the same cycle as a loss forces a restart regardless of AUTO_RELOCK.
            if (!all_active) begin
               if (loss_q != 8'hFF) begin
                  loss_d = loss_q + 8'd1;
               end
               cnt_d = '0;
               if (start_i || AUTO_RELOCK) begin
                  state_d   = StReset;
                  retries_d = '0;
               end else begin
                  state_d = StFailed;
               end
            end else if (start_i) begin
               state_d   = StReset;
               cnt_d     = '0;
               retries_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (retry) begin
         cnt_d = '0;
         if (retries_q == RetW'(MAX_RETRY)) begin
            state_d = StFailed;
         end else begin
            state_d   = StReset;
            retries_d = retries_q + RetW'(1);
         end
      end

      fifo_rst_d = (state_d == StIdle) || (state_d == StReset) || (state_d == StFailed);
      busy_d     = (state_d == StReset) || (state_d == StWait) || (state_d == StSettle);
      locked_d   = (state_d == StLocked);
      failed_d   = (state_d == StFailed);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         retries_q  <= '0;
         loss_q     <= '0;
         fifo_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         locked_q   <= 1'b0;
         failed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retries_q  <= retries_d;
         loss_q     <= loss_d;
         fifo_rst_q <= fifo_rst_d;
         busy_q     <= busy_d;
         locked_q   <= locked_d;
         failed_q   <= failed_d;
      end
   end

   assign fifo_rst_o   = fifo_rst_q;
   assign busy_o       = busy_q;
   assign locked_o     = locked_q;
   assign failed_o     = failed_q;
   assign retries_o    = retries_q;
   assign loss_count_o = loss_q;

endmodule

// File: tb/tb_ritc_fifo_sync_ctrl.sv
// Bench for ritc_fifo_sync_ctrl: expected output snapshots are queued per edge number from the
// documented timing and compared as each edge is reached. A second instance runs AUTO_RELOCK=0.
module tb_ritc_fifo_sync_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic [3:0] active_i;

   logic       fifo_rst, busy, locked, failed;
   logic [1:0] retries;
   logic [7:0] loss;
   logic       fifo_rst_nr, busy_nr, locked_nr, failed_nr;
   logic [1:0] retries_nr;
   logic [7:0] loss_nr;

   always #5 clk_i = ~clk_i;

   ritc_fifo_sync_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .active_i     (active_i),
      .fifo_rst_o   (fifo_rst),
      .busy_o       (busy),
      .locked_o     (locked),
      .failed_o     (failed),
      .retries_o    (retries),
      .loss_count_o (loss)
   );

   ritc_fifo_sync_ctrl #(.AUTO_RELOCK(1'b0)) dut_nr (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .active_i     (active_i),
      .fifo_rst_o   (fifo_rst_nr),
      .busy_o       (busy_nr),
      .locked_o     (locked_nr),
      .failed_o     (failed_nr),
      .retries_o    (retries_nr),
      .loss_count_o (loss_nr)
   );

   typedef struct {
      int          ed;
      bit          nr;
      string       nm;
      logic [13:0] v;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          edge_n = 0;
   logic [13:0] obs, obs_nr, got;

   assign obs    = {fifo_rst, busy, locked, failed, retries, loss};
   assign obs_nr = {fifo_rst_nr, busy_nr, locked_nr, failed_nr, retries_nr, loss_nr};

   // Snapshot layout {fifo_rst, busy, locked, failed, retries[1:0], loss[7:0]}.
   function automatic logic [13:0] mk(input bit fr, input bit bz, input bit lk, input bit fl,
                                      input int rt, input int ls);
      return {fr, bz, lk, fl, 2'(rt), 8'(ls)};
   endfunction

   task automatic push(input int ed, input bit nr, input string nm, input logic [13:0] v);
      sb.push_back('{ed, nr, nm, v});
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      edge_n++;
   endtask

   task automatic apply_rst();
      rst_i    = 1'b1;
      start_i  = 1'b0;
      active_i = 4'h0;
      step();
      rst_i  = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_reset();
      edge_n = 0;
      push(1, 0, "rst_values", mk(1, 0, 0, 0, 0, 0));
      push(1, 1, "rst_values_nr", mk(1, 0, 0, 0, 0, 0));
      push(4, 0, "rst_idle_hold", mk(1, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 4; k++) begin
         rst_i    = (k == 1);
         start_i  = (k == 1);
         active_i = 4'hF;
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL rst_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_nominal();
      apply_rst();
      push(10, 0, "nom_reset", mk(1, 1, 0, 0, 0, 0));
      push(13, 0, "nom_reset_hold", mk(1, 1, 0, 0, 0, 0));
      push(14, 0, "nom_fifo_rst_fall", mk(0, 1, 0, 0, 0, 0));
      push(27, 0, "nom_settling", mk(0, 1, 0, 0, 0, 0));
      push(28, 0, "nom_locked", mk(0, 0, 1, 0, 0, 0));
      push(28, 1, "nom_locked_nr", mk(0, 0, 1, 0, 0, 0));
      push(32, 0, "nom_locked_hold", mk(0, 0, 1, 0, 0, 0));
      for (int k = 1; k <= 32; k++) begin
         start_i  = (k == 10);
         active_i = (k >= 20) ? 4'hF : 4'h0;
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL nom_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_retry();
      apply_rst();
      push(45, 0, "retry_wait_last", mk(0, 1, 0, 0, 0, 0));
      push(46, 0, "retry_repulse", mk(1, 1, 0, 0, 1, 0));
      push(49, 0, "retry_repulse_hold", mk(1, 1, 0, 0, 1, 0));
      push(50, 0, "retry_wait2", mk(0, 1, 0, 0, 1, 0));
      push(62, 0, "retry_settling", mk(0, 1, 0, 0, 1, 0));
      push(63, 0, "retry_locked", mk(0, 0, 1, 0, 1, 0));
      for (int k = 1; k <= 66; k++) begin
         start_i  = (k == 10);
         active_i = (k >= 55) ? 4'hF : 4'h0;
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL retry_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_hard_fail();
      apply_rst();
      push(46, 0, "hf_retry1", mk(1, 1, 0, 0, 1, 0));
      push(82, 0, "hf_retry2", mk(1, 1, 0, 0, 2, 0));
      push(118, 0, "hf_retry3", mk(1, 1, 0, 0, 3, 0));
      push(153, 0, "hf_last_wait", mk(0, 1, 0, 0, 3, 0));
      push(154, 0, "hf_failed", mk(1, 0, 0, 1, 3, 0));
      push(154, 1, "hf_failed_nr", mk(1, 0, 0, 1, 3, 0));
      push(160, 0, "hf_failed_hold", mk(1, 0, 0, 1, 3, 0));
      push(170, 0, "hf_restart", mk(1, 1, 0, 0, 0, 0));
      for (int k = 1; k <= 172; k++) begin
         start_i  = (k == 10) || (k == 170);
         active_i = 4'h7;
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL hf_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_settle_glitch();
      apply_rst();
      push(25, 0, "glitch_settling", mk(0, 1, 0, 0, 0, 0));
      push(26, 0, "glitch_retry", mk(1, 1, 0, 0, 1, 0));
      push(28, 0, "glitch_no_lock", mk(1, 1, 0, 0, 1, 0));
      push(30, 0, "glitch_wait2", mk(0, 1, 0, 0, 1, 0));
      push(38, 0, "glitch_settling2", mk(0, 1, 0, 0, 1, 0));
      push(39, 0, "glitch_locked", mk(0, 0, 1, 0, 1, 0));
      for (int k = 1; k <= 40; k++) begin
         start_i  = (k == 10);
         active_i = (k < 20) ? 4'h0 : ((k == 26) ? 4'hB : 4'hF);
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL glitch_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   // Loss j (0-based) lands at edge 32+14*j: 4 RESET + 1 WAIT + 8 SETTLE + 1 LOCKED cycles.
   task automatic test_loss();
      apply_rst();
      push(32, 0, "loss_first", mk(1, 1, 0, 0, 0, 1));
      push(32, 1, "loss_first_nr_failed", mk(1, 0, 0, 1, 0, 1));
      push(45, 0, "loss_relocked", mk(0, 0, 1, 0, 0, 1));
      push(45, 1, "loss_nr_stays_failed", mk(1, 0, 0, 1, 0, 1));
      push(46, 0, "loss_second", mk(1, 1, 0, 0, 0, 2));
      push(3574, 0, "loss_254", mk(1, 1, 0, 0, 0, 254));
      push(3588, 0, "loss_255", mk(1, 1, 0, 0, 0, 255));
      push(3602, 0, "loss_saturate", mk(1, 1, 0, 0, 0, 255));
      push(4218, 0, "loss_300", mk(1, 1, 0, 0, 0, 255));
      push(4231, 0, "loss_final_lock", mk(0, 0, 1, 0, 0, 255));
      push(4232, 1, "loss_nr_final", mk(1, 0, 0, 1, 0, 1));
      for (int k = 1; k <= 4232; k++) begin
         start_i = (k == 10);
         if (k < 20) active_i = 4'h0;
         else if (k >= 32 && (k - 32) % 14 == 0 && (k - 32) / 14 < 300) active_i = 4'hE;
         else active_i = 4'hF;
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL loss_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_edge_cases();
      apply_rst();
      push(51, 0, "edge_wait_r1", mk(0, 1, 0, 0, 1, 0));
      push(52, 0, "edge_rst_in_wait", mk(1, 0, 0, 0, 0, 0));
      push(55, 0, "edge_idle_after_rst", mk(1, 0, 0, 0, 0, 0));
      push(60, 0, "edge_restart", mk(1, 1, 0, 0, 0, 0));
      push(63, 0, "edge_start_in_reset", mk(1, 1, 0, 0, 0, 0));
      push(64, 0, "edge_wait_on_time", mk(0, 1, 0, 0, 0, 0));
      push(70, 0, "edge_start_in_wait", mk(0, 1, 0, 0, 0, 0));
      push(96, 0, "edge_timeout", mk(1, 1, 0, 0, 1, 0));
      push(104, 0, "edge_start_in_settle", mk(0, 1, 0, 0, 1, 0));
      push(109, 0, "edge_locked", mk(0, 0, 1, 0, 1, 0));
      push(112, 0, "edge_start_with_loss", mk(1, 1, 0, 0, 0, 1));
      push(112, 1, "edge_start_with_loss_nr", mk(1, 1, 0, 0, 0, 1));
      push(125, 0, "edge_relocked", mk(0, 0, 1, 0, 0, 1));
      push(125, 1, "edge_relocked_nr", mk(0, 0, 1, 0, 0, 1));
      for (int k = 1; k <= 126; k++) begin
         rst_i    = (k == 52);
         start_i  = (k == 10) || (k == 60) || (k == 62) || (k == 70) || (k == 104) ||
                    (k == 112);
         active_i = (k == 112) ? 4'hE : ((k >= 101) ? 4'hF : 4'h0);
         step();
         while (sb.size() > 0 && sb[0].ed == edge_n) begin
            e = sb.pop_front();
            got = e.nr ? obs_nr : obs;
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL %s edge %0d got %b_%0d_%0d want %b_%0d_%0d", e.nm, edge_n,
                        got[13:10], got[9:8], got[7:0], e.v[13:10], e.v[9:8], e.v[7:0]);
            end
         end
      end
      rst_i = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL edge_pending got %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      rst_i    = 1'b1;
      start_i  = 1'b0;
      active_i = 4'h0;
      test_reset();
      test_nominal();
      test_retry();
      test_hard_fail();
      test_settle_glitch();
      test_loss();
      test_edge_cases();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
